// File: rtl/perf_event_counter_bank_if.sv
// ============================================================================
// Module   : perf_event_counter_bank_if
// Purpose  : Control, event and readback bundle for the perf counter bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface perf_event_counter_bank_if #(
   parameter int NUM_CH = 6,
   parameter int CNT_W  = 32
);
   localparam int c_selW = $clog2(NUM_CH + 1);

   logic              enable;
   logic              clear;
   logic              halt;
   logic [NUM_CH-1:0] event_i;
   logic              snap;
   logic [c_selW-1:0] rd_sel;
   logic              rd_shadow;
   logic [CNT_W-1:0]  rd_data;
   logic [NUM_CH:0]   overflow;
   logic              frozen;

   modport master (
      output enable, clear, halt, event_i, snap, rd_sel, rd_shadow,
      input  rd_data, overflow, frozen
   );

   modport slave (
      input  enable, clear, halt, event_i, snap, rd_sel, rd_shadow,
      output rd_data, overflow, frozen
   );
endinterface

`default_nettype wire

// File: rtl/perf_event_counter_bank.sv
// ============================================================================
// Module   : perf_event_counter_bank
// Purpose  : NUM_CH event counters plus a cycle counter with shadow snapshot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_event_counter_bank #(
   parameter int NUM_CH   = 6,
   parameter int CNT_W    = 32,
   parameter int SAT_MODE = 0
) (
   input  wire logic clk,
   input  wire logic rst,
   perf_event_counter_bank_if.slave bus
);
   localparam int c_numCnt = NUM_CH + 1;
   localparam int c_selW   = $clog2(NUM_CH + 1);
   localparam logic [c_selW-1:0] c_maxSel = c_selW'(NUM_CH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FROZEN = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [CNT_W-1:0]    r_live   [c_numCnt];
   logic [CNT_W-1:0]    r_shadow [c_numCnt];
   logic [CNT_W-1:0]    w_post   [c_numCnt];
   logic [c_numCnt-1:0] w_incr;
   logic [c_numCnt-1:0] w_wrap;
   logic [c_numCnt-1:0] r_ovf;
   logic [CNT_W-1:0]    r_rdData;
   logic [CNT_W-1:0]    w_rdMux;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      if (bus.clear) begin
         w_nextState = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (bus.enable) w_nextState = RUN;
            RUN: begin
               if (bus.halt)         w_nextState = FROZEN;
               else if (!bus.enable) w_nextState = IDLE;
            end
            FROZEN:  w_nextState = FROZEN;
            default: w_nextState = IDLE;
         endcase
      end
   end

   // MSB of the increment vector is the cycle counter, which ticks every RUN cycle
   assign w_incr = (r_state == RUN) ? {1'b1, bus.event_i} : '0;

   always_comb begin
      w_wrap = '0;
      for (int i = 0; i < c_numCnt; i++) begin
         w_post[i] = r_live[i];
         if (w_incr[i]) begin
            if (&r_live[i]) begin
               w_wrap[i] = 1'b1;
               if (SAT_MODE == 0) w_post[i] = '0;
            end else begin
               w_post[i] = r_live[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      w_rdMux = '0;
      if (bus.rd_sel <= c_maxSel) begin
         w_rdMux = bus.rd_shadow ? r_shadow[bus.rd_sel] : r_live[bus.rd_sel];
      end
   end

   // Shadow captures the post-increment value even when clear zeroes the live bank
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ovf    <= '0;
         r_rdData <= '0;
         for (int i = 0; i < c_numCnt; i++) begin
            r_live[i]   <= '0;
            r_shadow[i] <= '0;
         end
      end else begin
         r_ovf    <= bus.clear ? '0 : (r_ovf | w_wrap);
         r_rdData <= w_rdMux;
         for (int i = 0; i < c_numCnt; i++) begin
            r_live[i] <= bus.clear ? '0 : w_post[i];
            if (bus.snap) r_shadow[i] <= w_post[i];
         end
      end
   end

   assign bus.rd_data  = r_rdData;
   assign bus.overflow = r_ovf;
   assign bus.frozen   = (r_state == FROZEN);
endmodule

`default_nettype wire

// File: tb/tb_perf_event_counter_bank.sv
// ============================================================================
// Module   : tb_perf_event_counter_bank
// Purpose  : Scoreboarded bench for a 32-bit wrap bank and 8-bit wrap/sat banks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_perf_event_counter_bank;
   localparam int NUM_CH = 6;
   localparam int SEL_W  = $clog2(NUM_CH + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              enable, clear, halt, snap, rdShadow;
   logic [NUM_CH-1:0] eventI;
   logic [SEL_W-1:0]  rdSel;

   perf_event_counter_bank_if #(.NUM_CH(NUM_CH), .CNT_W(32)) busMain ();
   perf_event_counter_bank_if #(.NUM_CH(NUM_CH), .CNT_W(8))  busWrap ();
   perf_event_counter_bank_if #(.NUM_CH(NUM_CH), .CNT_W(8))  busSat ();

   assign busMain.enable = enable;   assign busWrap.enable = enable;   assign busSat.enable = enable;
   assign busMain.clear = clear;     assign busWrap.clear = clear;     assign busSat.clear = clear;
   assign busMain.halt = halt;       assign busWrap.halt = halt;       assign busSat.halt = halt;
   assign busMain.event_i = eventI;  assign busWrap.event_i = eventI;  assign busSat.event_i = eventI;
   assign busMain.snap = snap;       assign busWrap.snap = snap;       assign busSat.snap = snap;
   assign busMain.rd_sel = rdSel;    assign busWrap.rd_sel = rdSel;    assign busSat.rd_sel = rdSel;
   assign busMain.rd_shadow = rdShadow; assign busWrap.rd_shadow = rdShadow; assign busSat.rd_shadow = rdShadow;

   perf_event_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(32), .SAT_MODE(0)) dutMain (.clk(clk), .rst(rst), .bus(busMain));
   perf_event_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(8),  .SAT_MODE(0)) dutWrap (.clk(clk), .rst(rst), .bus(busWrap));
   perf_event_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(8),  .SAT_MODE(1)) dutSat  (.clk(clk), .rst(rst), .bus(busSat));

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [63:0] expMain;
      logic [63:0] expWrap;
      logic [63:0] expSat;
   } rdExp_t;

   rdExp_t sbQ[$];
   int     nChecks = 0;
   int     nFails  = 0;

   task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reads are registered at the edge following the request; compare just after it
   always @(posedge clk) begin
      #1;
      while (sbQ.size() > 0) begin
         rdExp_t e;
         e = sbQ.pop_front();
         checkEq({e.tag, "/main"}, 64'(busMain.rd_data), e.expMain);
         checkEq({e.tag, "/wrap"}, 64'(busWrap.rd_data), e.expWrap);
         checkEq({e.tag, "/sat"},  64'(busSat.rd_data),  e.expSat);
      end
   end

   task automatic readExp(input int sel, input bit sh, input string tag,
                          input logic [63:0] eM, input logic [63:0] eW, input logic [63:0] eS);
      rdSel    = SEL_W'(sel);
      rdShadow = sh;
      sbQ.push_back('{tag, eM, eW, eS});
      @(negedge clk);
   endtask

   task automatic readSame(input int sel, input bit sh, input string tag, input logic [63:0] e);
      readExp(sel, sh, tag, e, e, e);
   endtask

   // Enable for n edges after the IDLE->RUN edge; the edge dropping to IDLE still counts
   task automatic runBurst(input logic [NUM_CH-1:0] ev, input int n);
      enable = 1'b1;
      eventI = ev;
      repeat (n) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      eventI = '0;
   endtask

   task automatic doClear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic checkOvf(input string tag, input logic [63:0] eM, input logic [63:0] eW, input logic [63:0] eS);
      checkEq({tag, "/main"}, 64'(busMain.overflow), eM);
      checkEq({tag, "/wrap"}, 64'(busWrap.overflow), eW);
      checkEq({tag, "/sat"},  64'(busSat.overflow),  eS);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; enable = 1'b0; clear = 1'b0; halt = 1'b0; snap = 1'b0;
      rdShadow = 1'b0; eventI = '0; rdSel = '0;
      repeat (3) @(negedge clk);
      checkEq("rst_rdData", 64'(busMain.rd_data), 64'd0);
      checkEq("rst_frozen", 64'(busMain.frozen), 64'd0);
      checkOvf("rst_ovf", 64'd0, 64'd0, 64'd0);
      rst = 1'b1;

      // Events without enable never reach the counters
      eventI = '1;
      repeat (20) @(negedge clk);
      eventI = '0;
      for (int c = 0; c <= NUM_CH; c++) readSame(c, 1'b0, $sformatf("idleDrop%0d", c), 64'd0);

      runBurst(NUM_CH'(1), 10);
      readSame(0, 1'b0, "t1_ch0", 64'd10);
      readSame(NUM_CH, 1'b0, "t1_cyc", 64'd10);
      readSame(1, 1'b0, "t1_ch1", 64'd0);

      doClear();
      runBurst(NUM_CH'(2), 260);
      readExp(1, 1'b0, "t2_ch1", 64'd260, 64'd4, 64'd255);
      readExp(NUM_CH, 1'b0, "t2_cyc", 64'd260, 64'd4, 64'd255);
      readSame(0, 1'b0, "t2_ch0", 64'd0);
      checkOvf("t2_ovf", 64'd0, 64'h42, 64'h42);

      doClear();
      checkOvf("clr_ovf", 64'd0, 64'd0, 64'd0);
      enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      halt = 1'b1; eventI = '1;
      @(negedge clk);
      halt = 1'b0;
      checkEq("t3_frozen", 64'(busMain.frozen), 64'd1);
      for (int k = 0; k < 6; k++) begin
         enable = ~enable;
         halt   = (k == 3);
         @(negedge clk);
      end
      enable = 1'b0; halt = 1'b0; eventI = '0;
      for (int c = 0; c < NUM_CH; c++) readSame(c, 1'b0, $sformatf("t3_ch%0d", c), 64'd1);
      readSame(NUM_CH, 1'b0, "t3_cyc", 64'd2);
      checkEq("t3_stillFrozen", 64'(busSat.frozen), 64'd1);
      doClear();
      checkEq("t3_unfrozen", 64'(busMain.frozen), 64'd0);
      readSame(0, 1'b0, "t3_clrCh0", 64'd0);
      readSame(NUM_CH, 1'b0, "t3_clrCyc", 64'd0);

      enable = 1'b1;
      @(negedge clk);
      eventI = NUM_CH'(4);
      repeat (5) @(negedge clk);
      snap = 1'b1; clear = 1'b1;
      @(negedge clk);
      snap = 1'b0; clear = 1'b0; enable = 1'b0; eventI = '0;
      readSame(2, 1'b1, "t4_shCh2", 64'd6);
      readSame(NUM_CH, 1'b1, "t4_shCyc", 64'd6);
      readSame(0, 1'b1, "t4_shCh0", 64'd0);
      readSame(2, 1'b0, "t4_liveCh2", 64'd0);
      readSame(NUM_CH, 1'b0, "t4_liveCyc", 64'd0);

      readSame(NUM_CH + 1, 1'b0, "t5_selOob", 64'd0);
      readSame(NUM_CH + 1, 1'b1, "t5_selOobSh", 64'd0);
      enable = 1'b1; eventI = '1;
      @(negedge clk);
      readSame(NUM_CH, 1'b0, "t5_preUpd0", 64'd0);
      readSame(NUM_CH, 1'b0, "t5_preUpd1", 64'd1);
      readSame(0, 1'b0, "t5_ch0Run", 64'd2);
      snap = 1'b1;
      @(negedge clk);
      snap = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1; enable = 1'b0;
      checkEq("t5_rstRdData", 64'(busMain.rd_data), 64'd0);
      checkEq("t5_rstFrozen", 64'(busMain.frozen), 64'd0);
      checkOvf("t5_rstOvf", 64'd0, 64'd0, 64'd0);
      readSame(0, 1'b0, "t5_rstCh0", 64'd0);
      readSame(NUM_CH, 1'b1, "t5_rstShCyc", 64'd0);
      readSame(2, 1'b1, "t5_rstShCh2", 64'd0);
      readSame(NUM_CH, 1'b0, "t5_rstCyc", 64'd0);
      eventI = '0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule

`default_nettype wire
